axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares the single AXI read-address/read-data channel between the IF (inst) and EX/MEM (data) SRAM-like
//  read ports. Fixed data-over-inst priority. Per-requester outstanding-read limit. Routes R beats back by rid.
//  Sits between the pipeline SRAM-like ports and the AXI AR/R pins of mycpu_top. Write channels are out of scope.
// PARAMETERS
//  MAX_OUTST  2     max in-flight reads per requester (1..7); counter width 3
//  INST_ID    4'd0  arid used for inst reads
//  DATA_ID    4'd1  arid used for data reads
// PORTS
//  aclk          in   1   clock
//  reset         in   1   synchronous reset, active-high
//  inst_req      in   1   inst read request; held with addr/size until inst_addr_ok
//  inst_addr     in   32  inst read address
//  inst_size     in   2   bytes = 1<<size
//  inst_addr_ok  out  1   request accepted this cycle
//  inst_data_ok  out  1   inst read data valid this cycle
//  inst_rdata    out  32  inst read data
//  data_req/data_addr/data_size/data_addr_ok/data_data_ok/data_rdata: same as inst_*, for the data port
//  arid          out  4   AR id
//  araddr        out  32  AR address
//  arsize        out  3   {1'b0,size}
//  arvalid       out  1   AR valid
//  arready       in   1   AR ready
//  rid           in   4   R id
//  rdata         in   32  R data
//  rvalid        in   1   R valid
//  rready        out  1   R ready
//  wr_pend       in   1   a data write is in flight (RAW check)
//  wr_pend_addr  in   32  address of the in-flight write
// BEHAVIOUR
//  Reset: state=IDLE; arvalid=0, arid=0, araddr=0, arsize=0, rready=0, both counters=0; addr_ok/data_ok=0.
//  rready: register, 1 from the first cycle after reset deasserts; held at 1 thereafter.
//  FSM IDLE: grant_d = data_req & cnt_d<MAX_OUTST & ~raw_blk; grant_i = inst_req & cnt_i<MAX_OUTST & ~grant_d.
//   Grant -> comb. addr_ok to the winner in the same cycle; latch id/addr/size; next state AR. No grant -> stay.
//  FSM AR: arvalid=1; arid/araddr/arsize stable; no new grant. arvalid&arready -> IDLE next cycle.
//   Throughput: 1 AR per 2 cycles max; addr_ok->arvalid latency 1 cycle.
//  Counters: +1 on the owner's addr_ok; -1 on rvalid&rready&rid==own id; both same cycle -> unchanged.
//   cnt==MAX_OUTST blocks that requester only; the other still wins.
//  R routing (comb.): x_data_ok = rvalid & rready & rid==X_ID; x_rdata = rdata.
//   rid matching neither id is consumed (rready=1) and dropped; no data_ok, no counter change.
//  Ordering: same-id responses return in issue order (AXI rule); no reordering buffer.
//  Simultaneous inst_req & data_req -> data wins; inst retried next IDLE cycle.
//  Reset mid-transaction: all state cleared next edge, pending AR abandoned (system-wide reset only).
// CONFIGURATION
//  RD_RAW_CHECK_EN defined: raw_blk = wr_pend & (data_addr[31:2]==wr_pend_addr[31:2]);
//   data read to the same word as a pending write is not granted until wr_pend=0; inst reads unaffected.
//  Undefined: raw_blk=0; wr_pend/wr_pend_addr ignored.
// TESTING
//  1 inst_req addr=0x1C000000 size=2, arready=1, R rid=0 rdata=0x02800000 -> inst_addr_ok cyc0, arvalid cyc1
//    arid=0 arsize=3'b010, inst_data_ok with inst_rdata=0x02800000, cnt_i back to 0.
//  2 inst_req & data_req same cycle (data 0x1C008000) -> data_addr_ok first, arid=1; inst_addr_ok next IDLE,
//    arid=0; R rid=1 then rid=0 -> data_data_ok then inst_data_ok, no cross-routing.
//  3 arready=0 for 5 cycles -> arvalid, arid, araddr stable all 5 cycles; no further addr_ok in any port.
//  4 MAX_OUTST=2, no R beats: 2 inst grants, 3rd inst_req held with addr_ok=0; data_req still granted;
//    one R rid=0 beat -> 3rd inst grant accepted; same-cycle grant+R on inst -> cnt_i unchanged.
//  5 RD_RAW_CHECK_EN, wr_pend=1 wr_pend_addr=0x1C008004, data_req addr=0x1C008006 -> no data_addr_ok;
//    addr 0x1C008008 -> granted; wr_pend->0 -> 0x1C008006 granted next cycle. Without macro: granted at once.
//  6 reset asserted in AR state with arvalid=1 -> next cycle arvalid=0, rready=0, counters=0, state IDLE.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR/R channel between the inst and data SRAM-like read ports.
// Fixed data-over-inst priority, per-requester outstanding-read limit, R beats routed by rid.
// Optional feature macro: RD_RAW_CHECK_EN blocks data reads that hit the word of a pending write.
module axi_rd_arbiter #(
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [3:0]  INST_ID   = 4'd0,
  parameter logic [3:0]  DATA_ID   = 4'd1
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  input  logic        wr_pend,
  input  logic [31:0] wr_pend_addr
);

  typedef enum logic [0:0] {StIdle, StAr} state_e;

  localparam logic [2:0] MaxCnt = 3'(MAX_OUTST);

  state_e     state_q;
  logic [2:0] cnt_inst_q;
  logic [2:0] cnt_data_q;
  logic       raw_blk;
  logic       grant_d;
  logic       grant_i;
  logic       inst_ret;
  logic       data_ret;

`ifdef RD_RAW_CHECK_EN
  // Byte offset within the word is irrelevant to the hazard.
  logic unused_wr;
  assign unused_wr = ^wr_pend_addr[1:0];
  assign raw_blk   = wr_pend & (data_addr[31:2] == wr_pend_addr[31:2]);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_pend, wr_pend_addr};
  assign raw_blk   = 1'b0;
`endif

  // Grant decision: only in IDLE, data first, each side gated by its own outstanding limit.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!reset && state_q == StIdle) begin
      grant_d = data_req & (cnt_data_q < MaxCnt) & ~raw_blk;
      grant_i = inst_req & (cnt_inst_q < MaxCnt) & ~grant_d;
    end
  end

  // R routing: every beat is consumed; ids matching neither port are dropped.
  always_comb begin
    data_ret = ~reset & rvalid & rready & (rid == DATA_ID);
    inst_ret = ~reset & rvalid & rready & (rid == INST_ID);
  end

  assign data_addr_ok = grant_d;
  assign inst_addr_ok = grant_i;
  assign data_data_ok = data_ret;
  assign inst_data_ok = inst_ret;
  assign data_rdata   = rdata;
  assign inst_rdata   = rdata;

  // AR FSM with registered channel outputs; the address phase stays frozen until the handshake.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= StIdle;
      arvalid <= 1'b0;
      arid    <= 4'd0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
      rready  <= 1'b0;
    end else begin
      rready <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            arid    <= DATA_ID;
            araddr  <= data_addr;
            arsize  <= {1'b0, data_size};
            arvalid <= 1'b1;
            state_q <= StAr;
          end else if (grant_i) begin
            arid    <= INST_ID;
            araddr  <= inst_addr;
            arsize  <= {1'b0, inst_size};
            arvalid <= 1'b1;
            state_q <= StAr;
          end
        end
        StAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  // Outstanding counters: +1 on own grant, -1 on own returned beat, both cancel out.
  always_ff @(posedge aclk) begin
    if (reset) begin
      cnt_inst_q <= 3'd0;
      cnt_data_q <= 3'd0;
    end else begin
      cnt_inst_q <= cnt_inst_q + {2'b00, grant_i} - {2'b00, inst_ret};
      cnt_data_q <= cnt_data_q + {2'b00, grant_d} - {2'b00, data_ret};
    end
  end

endmodule
